// File: rtl/phase_diff_pkg.sv
// Shared Q-format constants and state encoding for the phase-difference path.
// phase2speed uses the same constants, so both blocks agree on what π means.
package phase_diff_pkg;

  localparam int PW       = 18;      // signed Q3.15 radians
  localparam int PI_Q     = 102944;  // π in Q3.15
  localparam int TWO_PI_Q = 205887;  // 2π in Q3.15

  // Sized copies so comparisons and arithmetic stay at the datapath width.
  localparam logic signed [PW-1:0] PI_IN    = PW'(PI_Q);
  localparam logic signed [PW:0]   PI_D     = (PW+1)'(PI_Q);
  localparam logic signed [PW:0]   TWO_PI_D = (PW+1)'(TWO_PI_Q);

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } state_t;

endpackage

// File: rtl/phase_wrap.sv
// Combinational modulo-2π fold of a Q4.15 phase difference into [-π, π].
// Exactly ±π passes through unchanged.
module phase_wrap
  import phase_diff_pkg::*;
(
  input  logic signed [PW:0] d,
  output logic signed [PW:0] wrapped
);

  always_comb begin
    wrapped = d;
    if (d > PI_D) begin
      wrapped = d - TWO_PI_D;
    end else if (d < -PI_D) begin
      wrapped = d + TWO_PI_D;
    end
  end

endmodule

// File: rtl/phase_diff.sv
// Wrapped phase increment between consecutive phase samples: clamp, subtract
// the stored reference, fold into [-π, π], emit with a one-cycle ready strobe.
module phase_diff
  import phase_diff_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 sample,
  input  logic signed [PW-1:0] phase_in,
  output logic signed [PW:0]   phasediff,
  output logic                 ready,
  output logic                 range_err
);

  state_t state_reg, state_next;
  logic   launch;

  logic signed [PW-1:0] prev_reg;
  logic signed [PW-1:0] clamped;
  logic                 out_of_range;
  logic signed [PW:0]   diff_raw;
  logic signed [PW:0]   d1_reg;
  logic                 v1_reg;
  logic signed [PW:0]   wrapped;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // clear with sample re-arms on the new reference without launching.
  always_comb begin
    state_next = state_reg;
    launch     = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (sample) state_next = PRIMED;
      end
      PRIMED: begin
        if (sample && !clear) launch = 1'b1;
      end
      default: state_next = EMPTY;
    endcase
    if (clear) begin
      state_next = sample ? PRIMED : EMPTY;
    end
  end

  always_comb begin
    clamped      = phase_in;
    out_of_range = 1'b0;
    if (phase_in > PI_IN) begin
      clamped      = PI_IN;
      out_of_range = 1'b1;
    end else if (phase_in < -PI_IN) begin
      clamped      = -PI_IN;
      out_of_range = 1'b1;
    end
  end

  // Both operands lie in [-π, π], so one extra bit holds the difference.
  assign diff_raw = {clamped[PW-1], clamped} - {prev_reg[PW-1], prev_reg};

  phase_wrap u_wrap (
    .d       (d1_reg),
    .wrapped (wrapped)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_reg  <= '0;
      d1_reg    <= '0;
      v1_reg    <= 1'b0;
      phasediff <= '0;
      ready     <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (sample) prev_reg <= clamped;
      if (sample && out_of_range) range_err <= 1'b1;
      v1_reg <= launch;
      if (launch) d1_reg <= diff_raw;
      ready <= v1_reg;
      if (v1_reg) phasediff <= wrapped;
    end
  end

endmodule

// File: tb/tb_phase_diff.sv
// Directed plus randomized bench for phase_diff, checked every cycle against
// an event-queue model of the clamp / difference / wrap rules.
module tb_phase_diff;

  localparam int PI_Q     = 102944;
  localparam int TWO_PI_Q = 205887;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               sample;
  logic signed [17:0] phase_in;
  logic signed [18:0] phasediff;
  logic               ready;
  logic               range_err;

  phase_diff dut (
    .clock     (clk),
    .reset     (rst_n),
    .clear     (clear),
    .sample    (sample),
    .phase_in  (phase_in),
    .phasediff (phasediff),
    .ready     (ready),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int val;
  } ev_t;

  ev_t q[$];
  int  cyc      = 0;
  bit  have_ref = 0;
  int  m_prev   = 0;
  int  m_pd     = 0;
  bit  m_err    = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  function automatic int wrap_ref(input int d);
    if (d > PI_Q) return d - TWO_PI_Q;
    if (d < -PI_Q) return d + TWO_PI_Q;
    return d;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
  endtask

  // One clock: drive inputs, advance the model on the edge, compare outputs.
  task automatic step(input bit s, input bit c, input int ph);
    int  cp;
    bit  exp_rdy;
    sample   = s;
    clear    = c;
    phase_in = ph[17:0];
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      q.delete();
      have_ref = 0;
      m_prev   = 0;
      m_pd     = 0;
      m_err    = 0;
    end else if (s) begin
      cp = ph;
      if (ph > PI_Q) begin cp = PI_Q; m_err = 1; end
      else if (ph < -PI_Q) begin cp = -PI_Q; m_err = 1; end
      if (have_ref && !c) q.push_back('{due: cyc + 1, val: wrap_ref(cp - m_prev)});
      m_prev   = cp;
      have_ref = 1;
    end else if (c) begin
      have_ref = 0;
    end
    exp_rdy = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rdy = 1;
      m_pd    = q[0].val;
      void'(q.pop_front());
    end
    #1;
    chk("ready", ready, exp_rdy);
    chk("phasediff", phasediff, m_pd);
    chk("range_err", range_err, m_err);
    $display("cyc=%0d s=%0b c=%0b ph=%0d -> ready=%0b pd=%0d err=%0b",
             cyc, s, c, ph, ready, phasediff, range_err);
  endtask

  task automatic lit(input string tag, input int val);
    chk(tag, phasediff, val);
  endtask

  initial begin
    rst_n = 1'b0; sample = 1'b0; clear = 1'b0; phase_in = '0;
    step(0, 0, 0);
    step(1, 0, 5000);      // ignored under reset
    chk("reset_pd", phasediff, 0);
    chk("reset_ready", ready, 0);
    rst_n = 1'b1;

    // Basic differences
    step(1, 0, 0);
    step(1, 0, 1000);
    step(1, 0, 3000);
    lit("basic_1000", 1000);
    step(0, 0, 0);
    lit("basic_2000", 2000);

    // Positive and negative wrap
    step(1, 0, 100000);
    step(1, 0, -100000);
    step(0, 0, 0);
    lit("wrap_pos", 5887);
    step(1, 0, 100000);
    step(0, 0, 0);
    lit("wrap_neg", -5887);

    // Wrap boundary
    step(1, 1, 0);
    step(1, 0, 102944);
    step(0, 0, 0);
    lit("pi_passes", 102944);
    step(1, 0, -102944);
    step(0, 0, 0);
    lit("minus_2pi_edge", -1);

    // Clamp and sticky error
    step(1, 1, 0);
    step(1, 0, 110000);
    step(0, 0, 0);
    lit("clamp", 102944);
    chk("range_err_set", range_err, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("range_err_sticky", range_err, 1);

    // Clear mid-stream, then clear+sample while EMPTY
    step(0, 1, 0);
    step(1, 0, 500);
    step(1, 0, 700);
    step(1, 1, 1200);
    step(1, 0, 2000);
    step(0, 0, 0);
    lit("after_clear", 800);
    step(0, 1, 0);
    step(1, 1, 4000);
    step(1, 0, 4100);
    step(0, 0, 0);
    lit("clear_sample_primes", 100);

    // Reset one cycle after a PRIMED sample
    step(1, 0, 5000);
    rst_n = 1'b0;
    step(0, 0, 0);
    rst_n = 1'b1;
    chk("rst_mid_pd", phasediff, 0);
    chk("rst_mid_err", range_err, 0);
    step(1, 0, 7000);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_mid_no_ready", ready, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int ph;
      if ($urandom_range(0, 7) == 0) ph = int'($urandom_range(0, 262143)) - 131072;
      else ph = int'($urandom_range(0, 2 * PI_Q)) - PI_Q;
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, ph);
      rst_n = 1'b1;
    end
    step(0, 0, 0);
    step(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phase_diff.md
# phase_diff

Computes the wrapped phase increment between consecutive instantaneous-phase samples from the Hilbert/CORDIC phase stage. It sits directly upstream of `phase2speed` and drives that block's `phase` and `sample` inputs. It keeps the previous sample and subtracts it from the new one. It folds the result into [-π, π] and emits it with a one-cycle `ready` strobe.

## Interface
- `PW`, 18: input phase width, signed Q3.15 radians.
- `PI_Q`, 102944: π in Q3.15.
- `TWO_PI_Q`, 205887: 2π in Q3.15.
- `clock`  in  1  single clock for the block; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `clear`  in  1  drops the stored reference and returns the block to EMPTY.
- `sample`  in  1  marks `phase_in` as valid in this cycle.
- `phase_in`  in  PW  signed instantaneous phase; legal range is [-PI_Q, PI_Q].
- `phasediff`  out  PW+1  signed Q4.15 wrapped increment; feeds `phase2speed.phase`.
- `ready`  out  1  one-cycle strobe; `phasediff` is valid while it is high.
- `range_err`  out  1  sticky flag: an out-of-range `phase_in` was seen.

## Operation
- State machine, two states:
  - EMPTY: no reference held. A `sample` clamps `phase_in`, stores it in `prev`, and moves to PRIMED. No output is launched.
  - PRIMED: each `sample` launches a difference into the pipeline, then loads the new clamped phase into `prev`.
  - `clear` forces EMPTY from either state.
- `clear` and `sample` in the same cycle: the sample becomes the new reference. The state ends in PRIMED and no output is launched.
- Clamping: `phase_in` > PI_Q is replaced by PI_Q, and `phase_in` < -PI_Q is replaced by -PI_Q. Either case sets `range_err`. Only reset clears `range_err`; `clear` does not.
- Stage 1:
  - `d1` = clamped `phase_in` − `prev`, sign-extended to PW+1 bits.
  - The range is [-2·PI_Q, 2·PI_Q], so it cannot overflow.
  - `v1` = launch.
- Stage 2 (wrap):
  - if `d1` > PI_Q, result = `d1` − TWO_PI_Q;
  - else if `d1` < -PI_Q, result = `d1` + TWO_PI_Q;
  - else result = `d1`.
  - Exactly ±PI_Q passes through unwrapped.
  - Result is registered into `phasediff`; `ready` is the registered `v1`.
- `clear` does not flush stages 1–2; results already in flight still emerge.
- `phasediff` holds its last value while `ready` is low.

## Timing
- Reset values:
  - `phasediff` = 0, `ready` = 0, `range_err` = 0.
  - `prev` = 0, `v1` = 0, state = EMPTY.
- Reset mid-operation discards everything in flight: no `ready` is produced for samples taken before the reset.
- Latency: a `sample` in cycle N (state PRIMED) gives `ready` high in cycle N+2.
- Throughput: one sample per cycle. Back-to-back samples give back-to-back `ready` pulses.
- There is no backpressure; the consumer must accept every `ready`. `phase2speed` samples every 5 cycles, which is within this rate.
- `sample` is ignored while `reset` is asserted.

## Structure
- Shared package holds `PW`, `PI_Q`, `TWO_PI_Q`, and the state enumeration {EMPTY, PRIMED}. `phase2speed` uses the same Q-format constants.
- One sub-module, `phase_wrap`: combinational modulo-2π fold used in stage 2. It is reusable by the downstream averaging logic.
- The top level contains the FSM, the clamp, `prev`, and the two pipeline registers.

## Test plan
- **Basic differences.** Reset low for 2 cycles, then release; then sample 0, 1000, 3000 on consecutive cycles.
  - No `ready` for the first sample.
  - `ready` at the 2nd and 3rd sample cycles +2, with `phasediff` = 1000 then 2000.
- **Positive wrap and negative wrap.**
  - `prev` = 100000, new = −100000: raw −200000, output `phasediff` = 5887.
  - `prev` = −100000, new = 100000: output `phasediff` = −5887.
- **Wrap boundary.** `prev` = 0, new = 102944 gives `phasediff` = 102944 (no wrap). Then new = −102944 from `prev` = 102944: raw −205888 < −PI_Q, so output = −1.
- **Clamp and sticky error.** `phase_in` = 110000 after `prev` = 0.
  - `range_err` goes to 1 and `phasediff` = 102944.
  - `range_err` stays 1 across `clear` and returns to 0 only after reset.
- **Clear behaviour.**
  - Stream of 4 samples, `clear` asserted with the 3rd: the 3rd produces no `ready` and the 4th's difference is relative to the 3rd.
  - In-flight results from samples 1–2 still emerge.
  - `clear` and `sample` together while EMPTY: no `ready`, state PRIMED.
- **Reset mid-pipeline.** Assert reset one cycle after a PRIMED sample: no `ready`, all outputs 0. The next sample after release only primes the block.
